// File: rtl/bitstream_serializer_if.sv
// bitstream_serializer_if: encoder-side byte group plus consumer-side byte stream of the serializer.
interface bitstream_serializer_if #(
    parameter int SER_BITSTREAM_WIDTH = 8,
    parameter int SER_ADDR_WIDTH = 4
);
    logic ser_flag_first;
    logic [SER_BITSTREAM_WIDTH-1:0] in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
    logic [2:0] in_flag_bitstream;
    logic in_flag_last;
    logic [SER_BITSTREAM_WIDTH-1:0] out_byte;
    logic out_valid, out_ready, out_last, out_done, out_overflow;
    logic [SER_ADDR_WIDTH:0] out_level;

    modport master (
        output ser_flag_first, in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
        output in_flag_bitstream, in_flag_last, out_ready,
        input out_byte, out_valid, out_last, out_done, out_overflow, out_level
    );
    modport slave (
        input ser_flag_first, in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
        input in_flag_bitstream, in_flag_last, out_ready,
        output out_byte, out_valid, out_last, out_done, out_overflow, out_level
    );
endinterface

// File: rtl/bitstream_serializer.sv
// bitstream_serializer: packs up to five encoder bytes per cycle into a byte FIFO and streams them out with last/done framing.
module bitstream_serializer #(
    parameter int SER_BITSTREAM_WIDTH = 8,
    parameter int SER_FIFO_DEPTH = 16,
    parameter int SER_ADDR_WIDTH = 4
) (
    input logic ser_clk,
    input logic ser_reset,
    bitstream_serializer_if.slave bus
);
    localparam int W = SER_BITSTREAM_WIDTH;
    localparam int AW = SER_ADDR_WIDTH;

    typedef enum logic {RUN, DONE} state_t;
    state_t state, state_next;

    logic [W-1:0] mem [SER_FIFO_DEPTH];
    logic [SER_FIFO_DEPTH-1:0] tag;
    logic [W-1:0] grp [5];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic [AW+1:0] free;
    logic [2:0] k;
    logic overflow, done, pop, head_last, run, last_in, admit, drop, survivors, tag_old, done_set;

    assign grp[0] = bus.in_bit_1;
    assign grp[1] = bus.in_bit_2;
    assign grp[2] = bus.in_bit_3;
    assign grp[3] = bus.in_bit_4;
    assign grp[4] = bus.in_bit_5;

    // A restart or the DONE state masks the encoder side entirely.
    assign run = (state == RUN) && !bus.ser_flag_first;
    assign k = (run && bus.in_flag_bitstream <= 3'd5) ? bus.in_flag_bitstream : 3'd0;
    assign last_in = run && bus.in_flag_last;
    assign pop = bus.out_valid && bus.out_ready;
    assign free = (AW+2)'(SER_FIFO_DEPTH) - {1'b0, level} + (AW+2)'(pop);
    assign admit = (k != 3'd0) && ((AW+2)'(k) <= free);
    assign drop = (k != 3'd0) && !admit;
    // An unattached last goes to the newest entry that outlives this cycle's pop.
    assign survivors = level != (AW+1)'(pop);
    assign tag_old = last_in && !admit && survivors;
    assign head_last = bus.out_valid && tag[rd_ptr];
    assign done_set = (pop && head_last) || (last_in && !admit && !survivors);

    assign bus.out_valid = level != '0;
    assign bus.out_byte = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.out_last = head_last;
    assign bus.out_done = done;
    assign bus.out_overflow = overflow;
    assign bus.out_level = level;

    always_ff @(posedge ser_clk or posedge ser_reset)
        if (ser_reset) state <= RUN;
        else state <= state_next;

    always_comb begin
        state_next = state;
        state_next = bus.ser_flag_first ? RUN : done_set ? DONE : state;
    end

    always_ff @(posedge ser_clk or posedge ser_reset) begin
        if (ser_reset || bus.ser_flag_first) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + (admit ? AW'(k) : '0);
            rd_ptr <= rd_ptr + AW'(pop);
            level <= level + (admit ? (AW+1)'(k) : '0) - (AW+1)'(pop);
            overflow <= overflow || drop;
            done <= done_set;
        end
    end

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge ser_clk) begin
        for (int i = 0; i < 5; i++)
            if (admit && 3'(i) < k) begin
                mem[wr_ptr + AW'(i)] <= grp[i];
                tag[wr_ptr + AW'(i)] <= last_in && (3'(i) == k - 3'd1);
            end
        if (tag_old) tag[wr_ptr - AW'(1)] <= 1'b1;
    end
endmodule

// File: tb/tb_bitstream_serializer.sv
// tb_bitstream_serializer: scoreboard bench; expected bytes are queued as groups are driven and compared as they leave.
module tb_bitstream_serializer;
    localparam int W = 8;
    localparam int D = 16;
    localparam int AW = 4;

    typedef struct {
        logic [W-1:0] b;
        logic l;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ent_t q[$];
    int checks = 0;
    int failures = 0;
    bit m_done = 0;
    bit m_ovf = 0;
    bit m_dn = 0;

    always #5 clk = ~clk;

    bitstream_serializer_if #(.SER_BITSTREAM_WIDTH(W), .SER_ADDR_WIDTH(AW)) bus ();

    bitstream_serializer #(
        .SER_BITSTREAM_WIDTH(W),
        .SER_FIFO_DEPTH(D),
        .SER_ADDR_WIDTH(AW)
    ) dut (
        .ser_clk(clk),
        .ser_reset(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, update the model, then step past the edge.
    task automatic cyc(input int k, input logic last, input logic ready, input logic first, input logic [39:0] data);
        int keff;
        bit pop, ptag, admit, nd;
        bus.in_flag_bitstream = 3'(k);
        bus.in_flag_last = last;
        bus.out_ready = ready;
        bus.ser_flag_first = first;
        bus.in_bit_1 = data[7:0];
        bus.in_bit_2 = data[15:8];
        bus.in_bit_3 = data[23:16];
        bus.in_bit_4 = data[31:24];
        bus.in_bit_5 = data[39:32];
        check("valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("byte", bus.out_byte, q[0].b);
            check("last", bus.out_last, q[0].l);
        end
        check("level", bus.out_level, q.size());
        check("done", bus.out_done, m_done);
        check("overflow", bus.out_overflow, m_ovf);
        pop = ready && q.size() != 0;
        ptag = pop && q[0].l;
        if (pop) void'(q.pop_front());
        keff = (m_dn || first || k > 5) ? 0 : k;
        admit = keff > 0 && keff <= D - q.size();
        nd = ptag;
        if (first) begin
            q.delete();
            m_ovf = 0;
            nd = 0;
            m_dn = 0;
        end else begin
            if (keff > 0 && !admit) m_ovf = 1;
            if (admit)
                for (int i = 0; i < keff; i++)
                    q.push_back('{b: data[8*i +: 8], l: last && i == keff - 1});
            if (last && !m_dn && !admit) begin
                if (q.size() > 0) q[$].l = 1'b1;
                else nd = 1;
            end
            if (nd) m_dn = 1;
        end
        m_done = nd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] burst;
        bus.ser_flag_first = 1'b0;
        bus.in_flag_bitstream = 3'd0;
        bus.in_flag_last = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_bit_1 = '0;
        bus.in_bit_2 = '0;
        bus.in_bit_3 = '0;
        bus.in_bit_4 = '0;
        bus.in_bit_5 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_level", bus.out_level, 0);
        check("rst_byte", bus.out_byte, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_done", bus.out_done, 0);
        check("rst_ovf", bus.out_overflow, 0);
        rst = 1'b0;

        // Burst ordering
        burst = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        cyc(5, 0, 1, 0, burst);
        check("burst_lvl", bus.out_level, 5);
        check("burst_head", bus.out_byte, 8'h11);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 40'h0);
            check("burst_lvl", bus.out_level, 32'(4 - i));
            if (i < 4) check("burst_head", bus.out_byte, 32'(burst[8*(i+1) +: 8]));
        end

        // Overflow drops the whole group and is cleared by a restart
        for (int i = 0; i < 3; i++) begin
            cyc(5, 0, 0, 0, 40'({$urandom(), $urandom()}));
            check("ovf_lvl", bus.out_level, 32'(5 * (i + 1)));
        end
        cyc(2, 0, 0, 0, 40'h0000_00beef);
        check("ovf_lvl", bus.out_level, 15);
        check("ovf_flag", bus.out_overflow, 1);
        cyc(0, 0, 0, 1, 40'h0);
        check("first_ovf", bus.out_overflow, 0);
        check("first_lvl", bus.out_level, 0);

        // A pop in the same cycle frees room for a full group
        cyc(5, 0, 0, 0, 40'({$urandom(), $urandom()}));
        cyc(5, 0, 0, 0, 40'({$urandom(), $urandom()}));
        cyc(2, 0, 0, 0, 40'({$urandom(), $urandom()}));
        check("pop_lvl12", bus.out_level, 12);
        cyc(5, 0, 1, 0, 40'({$urandom(), $urandom()}));
        check("pop_lvl16", bus.out_level, 16);
        repeat (16) cyc(0, 0, 1, 0, 40'h0);

        // Last on a group, then DONE ignores new input
        cyc(3, 1, 0, 0, 40'h00_00c3_b2a1);
        repeat (3) cyc(0, 0, 1, 0, 40'h0);
        check("grp_done", bus.out_done, 1);
        cyc(2, 0, 1, 0, 40'h0000_00_7777);
        check("done_ignore", bus.out_level, 0);
        check("done_pulse", bus.out_done, 0);
        cyc(0, 0, 1, 1, 40'h0);

        // Last with an empty FIFO
        cyc(0, 1, 1, 0, 40'h0);
        check("empty_done", bus.out_done, 1);
        check("empty_valid", bus.out_valid, 0);
        cyc(0, 0, 1, 1, 40'h0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 7), $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0, 40'({$urandom(), $urandom()}));
        cyc(0, 0, 1, 1, 40'h0);

        // Reset mid-drain
        cyc(5, 0, 0, 0, 40'({$urandom(), $urandom()}));
        cyc(2, 1, 0, 0, 40'({$urandom(), $urandom()}));
        check("pre_rst_lvl", bus.out_level, 7);
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_lvl", bus.out_level, 0);
        q.delete();
        m_done = 0;
        m_ovf = 0;
        m_dn = 0;
        @(posedge clk);
        #1;
        check("midrst_done", bus.out_done, 0);
        rst = 1'b0;
        repeat (4) cyc(0, 0, 1, 0, 40'h0);
        cyc(4, 1, 1, 0, 40'({$urandom(), $urandom()}));
        repeat (6) cyc(0, 0, 1, 0, 40'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
